// File: rtl/uart_tx.sv
// UART transmitter with a one-word holding register and 16x-tick bit timing.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick16,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(DATA_BITS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           sub_q, sub_d;
    logic [CW-1:0]        bitcnt_q, bitcnt_d;
    logic                 stopcnt_q, stopcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic accept;
    logic load;
    logic stop_last;

    assign accept    = in_valid && !hold_full_q;
    assign stop_last = (STOP_BITS == 2) ? stopcnt_q : 1'b1;

    // NOTE: every _d gets its current value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        bitcnt_d    = bitcnt_q;
        stopcnt_d   = stopcnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        tx_done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        load        = 1'b0;

        if (tick16) begin
            if (state_q != S_IDLE) begin
                sub_d = sub_q + 4'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        tx_d    = 1'b0;
                        sub_d   = 4'd0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (sub_q == 4'd15) begin
                        state_d  = S_DATA;
                        tx_d     = shift_q[0];
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    if (sub_q == 4'd15) begin
                        if (bitcnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_d = S_PARITY;
                            tx_d    = parity_q;
`else
                            state_d   = S_STOP;
                            tx_d      = 1'b1;
                            stopcnt_d = 1'b0;
`endif
                        end else begin
                            shift_d  = shift_q >> 1;
                            bitcnt_d = bitcnt_q + CW'(1);
                            tx_d     = shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (sub_q == 4'd15) begin
                        state_d   = S_STOP;
                        tx_d      = 1'b1;
                        stopcnt_d = 1'b0;
                    end
                end
`endif
                S_STOP: begin
                    if (sub_q == 4'd15) begin
                        if (stop_last) begin
                            tx_done_d = 1'b1;
                            // A queued word starts immediately so frames abut with no idle gap.
                            if (hold_full_q) begin
                                load    = 1'b1;
                                tx_d    = 1'b0;
                                state_d = S_START;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            stopcnt_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^hold_q;
`endif
        end
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sub_q       <= 4'd0;
            bitcnt_q    <= '0;
            stopcnt_q   <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            bitcnt_q    <= bitcnt_d;
            stopcnt_q   <= stopcnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            tx_done_q   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign in_ready = !hold_full_q;
    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random words against a bit-level frame model,
// with one DUT per stop-bit setting and tick16 every 4 clk.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick16;
    logic       sel;
    logic       drv_valid;
    logic [7:0] drv_data;

    logic in_valid0, in_ready0, tx0, busy0, done0;
    logic in_valid1, in_ready1, tx1, busy1, done1;

    assign in_valid0 = !sel && drv_valid;
    assign in_valid1 = sel && drv_valid;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tick16(tick16), .in_data(drv_data), .in_valid(in_valid0),
        .in_ready(in_ready0), .tx(tx0), .busy(busy0), .tx_done(done0)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tick16(tick16), .in_data(drv_data), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    wire m_valid = sel ? in_valid1 : in_valid0;
    wire m_ready = sel ? in_ready1 : in_ready0;
    wire m_tx    = sel ? tx1 : tx0;
    wire m_busy  = sel ? busy1 : busy0;
    wire m_done  = sel ? done1 : done0;

    always #5 clk = ~clk;

    logic [7:0] wq[$];
    logic [7:0] cur[$];
    bit         obs[$];
    bit         busy_s[$];
    bit         exp_q[$];
    int         done_idx[$];
    int         acc_idx[$];
    int         dcnt;
    int         f0;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Bus-functional process: samples handshake/tick mid-cycle, records line per tick, drives inputs.
    initial begin
        bit hs, tk;
        int cyc;
        cyc = 0;
        tick16 = 1'b0;
        drv_valid = 1'b0;
        drv_data = 8'h00;
        forever begin
            @(negedge clk);
            hs = m_valid && m_ready;
            tk = tick16;
            @(posedge clk);
            #1;
            if (tk) begin
                obs.push_back(m_tx);
                busy_s.push_back(m_busy);
                if (m_done) done_idx.push_back(obs.size() - 1);
            end
            if (m_done) dcnt++;
            if (hs && !rst && wq.size() > 0) begin
                acc_idx.push_back(obs.size());
                void'(wq.pop_front());
            end
            drv_valid = (wq.size() > 0);
            if (wq.size() > 0) drv_data = wq[0];
            cyc = (cyc + 1) % 4;
            tick16 = (cyc == 0);
        end
    end

    function automatic int flen(input int sb);
        return (1 + 8 + PAR + sb) * 16;
    endfunction

    // Reference frame: start 0, LSB-first data, optional even parity, sb stop bits; 16 ticks each.
    task automatic append_frame(input logic [7:0] w, input int sb);
        bit bits[$];
        int ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(((w >> i) & 8'h01) != 0);
            if (((w >> i) & 8'h01) != 0) ones++;
        end
        if (PAR == 1) bits.push_back((ones % 2) == 1);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        foreach (bits[i])
            for (int j = 0; j < 16; j++) exp_q.push_back(bits[i]);
    endtask

    task automatic clear_logs();
        obs.delete();
        busy_s.delete();
        done_idx.delete();
        acc_idx.delete();
        dcnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        wq.delete();
        @(posedge clk);
        #3;
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic find_launch();
        f0 = -1;
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i] == 1'b0) begin
                f0 = i;
                break;
            end
        end
    endtask

    task automatic run_case(input string name, input logic s);
        int sb, len, n, errs, lows, idx;
        sel = s;
        do_reset();
        sb  = s ? 2 : 1;
        len = flen(sb);
        n   = cur.size();
        exp_q.delete();
        foreach (cur[i]) begin
            append_frame(cur[i], sb);
            wq.push_back(cur[i]);
        end
        repeat ((n * len + 48) * 4) @(posedge clk);
        #3;
        find_launch();
        check({name, " launch"}, int'(f0 >= 0 && f0 <= 2), 1);
        if (f0 < 0) f0 = 0;
        for (int b = 0; b < exp_q.size() / 16; b++) begin
            errs = 0;
            for (int j = 0; j < 16; j++) begin
                idx = f0 + 16 * b + j;
                if (idx >= obs.size() || obs[idx] != exp_q[16 * b + j]) errs++;
            end
            check($sformatf("%s bit%0d bad_ticks", name, b), errs, 0);
        end
        lows = 0;
        for (int i = f0 + n * len; i < obs.size(); i++) if (obs[i] == 1'b0) lows++;
        check({name, " idle_after low_ticks"}, lows, 0);
        lows = 0;
        for (int i = f0; i < f0 + n * len && i < busy_s.size(); i++) if (!busy_s[i]) lows++;
        check({name, " busy_drops"}, lows, 0);
        idx = f0 + n * len;
        check({name, " busy_after"}, (idx < busy_s.size()) ? int'(busy_s[idx]) : 1, 0);
        check({name, " done_pulses"}, dcnt, n);
        check({name, " done_count"}, done_idx.size(), n);
        for (int i = 0; i < done_idx.size() && i < n; i++)
            check($sformatf("%s done%0d_tick", name, i), done_idx[i], f0 + (i + 1) * len);
    endtask

    initial begin
        int lows, guard;
        rst = 1'b1;
        sel = 1'b0;
        dcnt = 0;
        #2;
        check("rst tx", int'(tx0), 1);
        check("rst in_ready", int'(in_ready0), 1);
        check("rst busy", int'(busy0), 0);
        check("rst tx_done", int'(done0), 0);
        repeat (3) @(posedge clk);

        cur = '{8'hA5};
        run_case("a5", 1'b0);
        cur = '{8'h07};
        run_case("07", 1'b0);
        cur = '{8'h00, 8'hFF};
        run_case("b2b", 1'b0);

        cur = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        run_case("hold3", 1'b0);
        check("hold3 acc_count", acc_idx.size(), 3);
        if (acc_idx.size() == 3) begin
            check("hold3 acc2_tick", acc_idx[1], f0 + 1);
            check("hold3 acc3_tick", acc_idx[2], f0 + flen(1) + 1);
        end

        cur = '{8'h55};
        run_case("stop2_55", 1'b1);
        cur = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        run_case("stop2_rnd", 1'b1);
        cur.delete();
        for (int i = 0; i < 4; i++) cur.push_back(8'($urandom_range(0, 255)));
        run_case("rnd4", 1'b0);

        // Reset 40 ticks into a frame with a second word already held.
        sel = 1'b0;
        do_reset();
        wq.push_back(8'($urandom_range(0, 255)));
        wq.push_back(8'($urandom_range(0, 255)));
        guard = 0;
        f0 = -1;
        while ((f0 < 0 || obs.size() < f0 + 40) && guard < 2000) begin
            @(posedge clk);
            #3;
            find_launch();
            guard++;
        end
        check("rstmid reached_tick40", int'(guard < 2000), 1);
        check("rstmid held_word_accepted", acc_idx.size(), 2);
        rst = 1'b1;
        #1;
        check("rstmid tx", int'(tx0), 1);
        check("rstmid in_ready", int'(in_ready0), 1);
        check("rstmid busy", int'(busy0), 0);
        check("rstmid done_before", dcnt, 0);
        @(posedge clk);
        #3;
        wq.delete();
        clear_logs();
        rst = 1'b0;
        repeat ((2 * flen(1) + 48) * 4) @(posedge clk);
        #3;
        lows = 0;
        foreach (obs[i]) if (obs[i] == 1'b0) lows++;
        check("rstmid line_low_ticks", lows, 0);
        check("rstmid done_after", dcnt, 0);
        lows = 0;
        foreach (busy_s[i]) if (busy_s[i]) lows++;
        check("rstmid busy_ticks", lows, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
